// File: rtl/program_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_ctrl
//  Description : Loads a program into CPU RAM, one byte per address. For each
//                byte it strobes the MAR address, waits for a byte, strobes the
//                MAR data, then writes. The CPU is held off the bus until the
//                block is released into RUN.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader_ctrl #(
  parameter int RAM_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic       run_start,
  input  logic       load_abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       bus_en,
  output logic [7:0] bus_out,
  output logic       nLma,
  output logic       nLmd,
  output logic       nWe,
  output logic       cpu_hold,
  output logic       done,
  output logic [7:0] checksum
);

  // Last RAM address of a session; the counter stops here and never wraps.
  localparam logic [3:0] LAST_ADDR = 4'(RAM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAITB = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5,
    S_RUN   = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] addr;
  logic [7:0] data_buf;
  logic [7:0] sum;
  logic       xfer;
  logic       session_go;

  // A byte moves only while waiting for one; a session opens from IDLE or RUN.
  assign xfer       = (state == S_WAITB) && byte_valid;
  assign session_go = load_start && ((state == S_IDLE) || (state == S_RUN));
  assign checksum   = sum;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and Moore output decode from the registered state.
  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    bus_en     = 1'b0;
    bus_out    = 8'h00;
    nLma       = 1'b1;
    nLmd       = 1'b1;
    nWe        = 1'b1;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) begin
          state_nx = S_ADDR;
        end else if (run_start) begin
          state_nx = S_RUN;
        end
      end
      S_ADDR: begin
        bus_en   = 1'b1;
        bus_out  = {4'b0000, addr};
        nLma     = 1'b0;
        state_nx = S_WAITB;
      end
      S_WAITB: begin
        byte_ready = 1'b1;
        // An arriving byte takes priority over an abort in the same cycle.
        if (xfer) begin
          state_nx = S_DATA;
        end else if (load_abort) begin
          state_nx = S_IDLE;
        end
      end
      S_DATA: begin
        bus_en   = 1'b1;
        bus_out  = data_buf;
        nLmd     = 1'b0;
        state_nx = S_WRITE;
      end
      S_WRITE: begin
        nWe      = 1'b0;
        state_nx = (addr == LAST_ADDR) ? S_FIN : S_ADDR;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        cpu_hold = 1'b0;
        if (load_start) begin
          state_nx = S_ADDR;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Address counter, byte buffer and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= 4'd0;
      data_buf <= 8'h00;
      sum      <= 8'h00;
    end else begin
      if (session_go) begin
        addr <= 4'd0;
        sum  <= 8'h00;
      end
      if (xfer) begin
        data_buf <= byte_in;
        sum      <= sum + byte_in;
      end
      if ((state == S_WRITE) && (addr != LAST_ADDR)) begin
        addr <= addr + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader_ctrl
//  Description : Scoreboard bench for program_loader_ctrl. Expected bus strobe
//                events are queued from a session-level model; a monitor pops
//                and compares each strobe the DUT produces.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader_ctrl;

  localparam int N = 16;
  localparam logic [1:0] K_LMA  = 2'd0;
  localparam logic [1:0] K_LMD  = 2'd1;
  localparam logic [1:0] K_WE   = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       load_start = 1'b0;
  logic       run_start  = 1'b0;
  logic       load_abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in    = 8'h00;
  logic       byte_ready, bus_en, nLma, nLmd, nWe, cpu_hold, done;
  logic [7:0] bus_out, checksum;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cyc    = 0;
  int done_count  = 0;
  int start_cyc   = 0;
  logic [1:0] n_low;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;
  ev_t        exp_q[$];
  logic [7:0] sess [N];

  program_loader_ctrl #(.RAM_BYTES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .run_start  (run_start),
    .load_abort (load_abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .bus_en     (bus_en),
    .bus_out    (bus_out),
    .nLma       (nLma),
    .nLmd       (nLmd),
    .nWe        (nWe),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic void observe(logic [1:0] kind, logic [7:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_strobe: got kind %0d value 0x%0h, expected no event (cycle %0d)",
               kind, val, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    chk("event_value", 32'(val), 32'(e.val));
  endfunction

  // Session model: each address produces an address load, a data load and a write.
  function automatic void expect_bytes(int lo, int hi);
    for (int a = lo; a <= hi; a++) begin
      exp_q.push_back(ev_t'{K_LMA, 8'(a)});
      exp_q.push_back(ev_t'{K_LMD, sess[a]});
      exp_q.push_back(ev_t'{K_WE, 8'h00});
    end
  endfunction

  function automatic logic [7:0] model_sum(int hi);
    int s = 0;
    for (int a = 0; a <= hi; a++) s += int'(sess[a]);
    return 8'(s % 256);
  endfunction

  function automatic void randomize_sess();
    for (int a = 0; a < N; a++) sess[a] = 8'($urandom);
  endfunction

  // Monitor: bus invariants every cycle, and strobe events against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      n_low = 2'({1'b0, !nLma} + {1'b0, !nLmd} + {1'b0, !nWe});
      chk("bus_en_one_mar_strobe", 32'(bus_en), 32'((!nLma) ^ (!nLmd)));
      chk("strobes_exclusive", 32'(n_low <= 2'd1), 32'd1);
      if (!bus_en) chk("bus_out_idle", 32'(bus_out), 32'd0);
      if (!nLma) observe(K_LMA, bus_out);
      if (!nLmd) observe(K_LMD, bus_out);
      if (!nWe)  observe(K_WE, 8'h00);
      if (done) begin
        done_cyc = cyc;
        done_count++;
        observe(K_DONE, checksum);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_bus_en",     32'(bus_en),     32'd0);
    chk("rst_bus_out",    32'(bus_out),    32'd0);
    chk("rst_nLma",       32'(nLma),       32'd1);
    chk("rst_nLmd",       32'(nLmd),       32'd1);
    chk("rst_nWe",        32'(nWe),        32'd1);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    chk("rst_checksum",   32'(checksum),   32'd0);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    start_cyc  = cyc;
    chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("start_checksum", 32'(checksum), 32'd0);
    chk("start_nLma",     32'(nLma),     32'd0);
    chk("start_addr0",    32'(bus_out),  32'd0);
  endtask

  task automatic wait_ready(input bit noise, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!byte_ready) begin
      byte_valid = noise ? 1'($urandom) : 1'b1;
      if (noise) byte_in = 8'($urandom);
      tick();
      n++;
      if (n > 20) begin
        vectors++;
        miscompares++;
        $display("FAIL byte_ready_timeout: byte_ready=0 after %0d cycles, expected 1", n);
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic feed(int lo, int hi, int max_gap, bit noise);
    bit ok;
    for (int a = lo; a <= hi; a++) begin
      byte_in = sess[a];
      wait_ready(noise, ok);
      if (!ok) return;
      repeat ($urandom_range(0, max_gap)) begin
        byte_valid = 1'b0;
        tick();
        chk("ready_held", 32'(byte_ready), 32'd1);
      end
      byte_valid = 1'b1;
      byte_in    = sess[a];
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(int prev);
    int n = 0;
    while (done_count == prev && n < 40) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_count), 32'(prev + 1));
  endtask

  task automatic expect_idle(int cycles);
    repeat (cycles) begin
      tick();
      chk("idle_cpu_hold",   32'(cpu_hold),   32'd1);
      chk("idle_byte_ready", 32'(byte_ready), 32'd0);
    end
  endtask

  initial begin
    bit ok;
    int d0;

    // Reset is asynchronous: outputs settle before any clock edge.
    #1 rst_n = 1'b0;
    #2 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_idle(2);

    // Counting bytes 0x00..0x0F with byte_valid held high.
    for (int a = 0; a < N; a++) sess[a] = 8'(a);
    expect_bytes(0, N - 1);
    exp_q.push_back(ev_t'{K_DONE, model_sum(N - 1)});
    byte_valid = 1'b1;
    byte_in    = sess[0];
    d0 = done_count;
    start_load();
    feed(0, N - 1, 0, 1'b0);
    wait_done(d0);
    chk("done_latency", 32'(done_cyc - start_cyc + 1), 32'(4 * N + 1));
    chk("checksum_0x78", 32'(checksum), 32'h78);
    chk("run_cpu_hold", 32'(cpu_hold), 32'd0);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    repeat (4) begin
      tick();
      chk("run_ignores_run_start", 32'(cpu_hold), 32'd0);
      chk("checksum_held", 32'(checksum), 32'h78);
    end

    // Random session launched from RUN.
    randomize_sess();
    expect_bytes(0, N - 1);
    exp_q.push_back(ev_t'{K_DONE, model_sum(N - 1)});
    d0 = done_count;
    start_load();
    feed(0, N - 1, 3, 1'b1);
    wait_done(d0);
    chk("run_after_random", 32'(cpu_hold), 32'd0);

    // Stall at address 5, then abort.
    randomize_sess();
    expect_bytes(0, 4);
    exp_q.push_back(ev_t'{K_LMA, 8'd5});
    d0 = done_count;
    start_load();
    feed(0, 4, 2, 1'b1);
    wait_ready(1'b1, ok);
    byte_valid = 1'b0;
    repeat (10) begin
      tick();
      chk("stall_ready", 32'(byte_ready), 32'd1);
    end
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    chk("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("abort_ready", 32'(byte_ready), 32'd0);
    chk("abort_partial_sum", 32'(checksum), 32'(model_sum(4)));
    expect_idle(4);
    chk("abort_no_done", 32'(done_count), 32'(d0));

    // load_start beats run_start; a byte beats load_abort.
    randomize_sess();
    sess[2] = 8'hAB;
    expect_bytes(0, N - 1);
    exp_q.push_back(ev_t'{K_DONE, model_sum(N - 1)});
    d0 = done_count;
    run_start = 1'b1;
    start_load();
    run_start = 1'b0;
    feed(0, 1, 1, 1'b1);
    wait_ready(1'b1, ok);
    byte_valid = 1'b1;
    byte_in    = 8'hAB;
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    byte_valid = 1'b0;
    chk("xfer_wins_bus_out", 32'(bus_out), 32'hAB);
    chk("xfer_wins_nLmd", 32'(nLmd), 32'd0);
    feed(3, N - 1, 2, 1'b1);
    wait_done(d0);

    // Abort at address 0 to reach IDLE, then release with run_start alone.
    exp_q.push_back(ev_t'{K_LMA, 8'd0});
    start_load();
    wait_ready(1'b1, ok);
    byte_valid = 1'b0;
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    expect_idle(2);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    chk("run_start_releases", 32'(cpu_hold), 32'd0);
    repeat (3) tick();

    // Reset during DATA of byte 7: no write for that byte, back to IDLE.
    randomize_sess();
    expect_bytes(0, 6);
    exp_q.push_back(ev_t'{K_LMA, 8'd7});
    start_load();
    feed(0, 7, 2, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_idle(6);

    // Two more random sessions from IDLE.
    repeat (2) begin
      randomize_sess();
      expect_bytes(0, N - 1);
      exp_q.push_back(ev_t'{K_DONE, model_sum(N - 1)});
      d0 = done_count;
      start_load();
      feed(0, N - 1, 3, 1'b1);
      wait_done(d0);
      chk("session_checksum", 32'(checksum), 32'(model_sum(N - 1)));
    end

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_loader_ctrl.md
PROGRAM_LOADER_CTRL -- requirements
Module: program_loader_ctrl

Interface
REQ-001 SHALL have parameter: RAM_BYTES, 16, number of RAM locations loaded per session (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: load_start  input  1  level-sampled request to begin a program-load session.
REQ-005 SHALL have port: run_start  input  1  request to release the CPU without loading.
REQ-006 SHALL have port: load_abort  input  1  abandon the session while waiting for a byte.
REQ-007 SHALL have port: byte_in  input  8  program byte from ui_in.
REQ-008 SHALL have port: byte_valid  input  1  byte_in valid; a transfer occurs when byte_valid and byte_ready are both 1 on a rising edge.
REQ-009 SHALL have port: byte_ready  output  1  loader can accept a byte.
REQ-010 SHALL have port: bus_en  output  1  loader drives the shared 8-bit bus; CPU bus drivers must be off.
REQ-011 SHALL have port: bus_out  output  8  value driven on the bus when bus_en=1, 8'h00 otherwise.
REQ-012 SHALL have port: nLma  output  1  MAR address load strobe, active-low.
REQ-013 SHALL have port: nLmd  output  1  MAR data load strobe, active-low.
REQ-014 SHALL have port: nWe  output  1  RAM write strobe, active-low.
REQ-015 SHALL have port: cpu_hold  output  1  freezes the CPU control sequencer while 1.
REQ-016 SHALL have port: done  output  1  one-cycle pulse when a full session completes.
REQ-017 SHALL have port: checksum  output  8  modulo-256 sum of bytes accepted in the current or last session.

Function
REQ-018 SHALL implement states IDLE, ADDR, WAITB, DATA, WRITE, FIN, RUN, all Moore-decoded from registered state.
REQ-019 IDLE: cpu_hold=1; load_start -> ADDR with addr=0, checksum=0; else run_start -> RUN; load_start wins if both are asserted.
REQ-020 ADDR: bus_en=1, bus_out={4'b0,addr}, nLma=0 for exactly one cycle -> WAITB.
REQ-021 WAITB: byte_ready=1; on a transfer, capture byte_in into data_buf, checksum+=byte_in -> DATA; else load_abort -> IDLE; a transfer wins over load_abort in the same cycle.
REQ-022 DATA: bus_en=1, bus_out=data_buf, nLmd=0 for one cycle -> WRITE.
REQ-023 WRITE: nWe=0 for one cycle; if addr==RAM_BYTES-1 -> FIN, else addr+=1 -> ADDR.
REQ-024 FIN: done=1 for one cycle -> RUN.
REQ-025 RUN: cpu_hold=0; load_start -> ADDR with addr=0, checksum=0, and cpu_hold=1 from the next cycle; run_start is ignored.
REQ-026 cpu_hold SHALL be 1 in every state except RUN.
REQ-027 byte_ready SHALL be 1 only in WAITB; byte_valid SHALL be ignored in all other states.
REQ-028 bus_en SHALL be 1 only in ADDR and DATA; nLma, nLmd and nWe SHALL never be low simultaneously.
REQ-029 The address counter SHALL be 4 bits wide and SHALL NOT wrap within a session; the session ends at RAM_BYTES-1.
REQ-030 Minimum session latency SHALL be 4*RAM_BYTES+1 cycles from load_start sampled to the done pulse, with byte_valid held high.
REQ-031 checksum SHALL hold its value after FIN until the next load_start acceptance.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state=IDLE, addr=0, data_buf=0, checksum=0, bus_en=0, bus_out=0, nLma=nLmd=nWe=1, byte_ready=0, done=0, cpu_hold=1.
REQ-033 Reset asserted mid-session SHALL abandon the session with no further strobes; after deassertion the block SHALL wait in IDLE.

Verification
REQ-034 Reset, then load_start=1 for 1 cycle, byte_valid=1 with bytes 0x00..0x0F -> 16 ADDR/DATA/WRITE triplets with bus_out addresses 0..15, done pulse at cycle 65, checksum=0x78, cpu_hold falls with RUN.
REQ-035 In IDLE, assert run_start=1 and load_start=1 together -> ADDR entered; only run_start=1 -> RUN, cpu_hold=0 next cycle, no strobes.
REQ-036 In WAITB at addr=5, byte_valid=0 for 10 cycles -> byte_ready stays 1, no strobes; then load_abort=1 -> IDLE, cpu_hold=1, done is never asserted.
REQ-037 In WAITB, byte_valid=1 and load_abort=1 in the same cycle with byte 0xAB -> byte accepted, DATA drives 0xAB, nLmd=0.
REQ-038 Pull rst_n low during DATA of byte 7 -> all outputs take reset values immediately (no clock edge) and nWe never pulses for byte 7.
REQ-039 In RUN, load_start=1 -> cpu_hold=1 next cycle, checksum=0, addr restarts at 0; in all scenarios, check that bus_en=1 only when exactly one of nLma or nLmd is low.
